// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions for the adder pipeline and related datapaths.
package fp_pkg;

   localparam int unsigned MAN_W = 23;
   localparam int unsigned EXP_W = 8;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam int unsigned BIAS = 127;

   typedef enum logic [1:0] {
      StIdle,
      StNorm,
      StRound,
      StOut
   } norm_state_t;

   // Assemble an IEEE-754 word from its three fields.
   function automatic logic [MAN_W+EXP_W:0] pack_fp(
      input logic             sign,
      input logic [EXP_W-1:0] exp,
      input logic [MAN_W-1:0] frac
   );
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalized mantissa with a single guard bit.
// Renormalizes on round carry-out and flags exponent saturation (overflow to infinity).
module fp_round_rne
   import fp_pkg::*;
#(
   parameter int unsigned ManW = MAN_W,
   parameter int unsigned ExpW = EXP_W
) (
   input  logic [ManW+1:0] man_i,
   input  logic [ExpW-1:0] exp_i,
   input  logic            guard_i,
   output logic [ManW+1:0] man_o,
   output logic [ExpW-1:0] exp_o,
   output logic            ovf_o
);

   logic [ManW+1:0] man_inc;

   // Guard-only tie handling: increment only when guard and lsb are both set (ties to even).
   always_comb begin
      man_inc = man_i + {{(ManW+1){1'b0}}, (guard_i & man_i[0])};
      man_o   = man_inc;
      exp_o   = exp_i;
      ovf_o   = 1'b0;
      if (exp_i == '1) begin
         // Exponent already saturated by the carry-out shift.
         ovf_o = 1'b1;
      end else begin
         if (man_inc[ManW+1]) begin
            man_o = man_inc >> 1;
            exp_o = exp_i + ExpW'(1);
         end
         ovf_o = (exp_o == '1);
      end
   end

endmodule

// File: rtl/stage4_normalizer.sv
// Final stage of the FP adder: normalizes the raw magnitude sum one bit per cycle,
// rounds to nearest-even, packs the IEEE-754 word and hands it off over valid/ready.
module stage4_normalizer
   import fp_pkg::*;
#(
   parameter int unsigned ManW = MAN_W,
   parameter int unsigned ExpW = EXP_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [ManW+1:0]    sum_man_i,
   input  logic               sum_sign_i,
   input  logic [ExpW-1:0]    exp_in_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [ManW+ExpW:0] result_o,
   output logic               overflow_o,
   output logic               underflow_o
);

   norm_state_t          state_q;
   logic [ManW+1:0]      man_q;
   logic [ExpW-1:0]      exp_q;
   logic                 sign_q;
   logic                 guard_q;
   logic [ManW+ExpW:0]   result_q;
   logic                 ovf_q;
   logic                 unf_q;

   logic [ManW+1:0]      rnd_man;
   logic [ExpW-1:0]      rnd_exp;
   logic                 rnd_ovf;

   fp_round_rne #(
      .ManW (ManW),
      .ExpW (ExpW)
   ) u_round (
      .man_i   (man_q),
      .exp_i   (exp_q),
      .guard_i (guard_q),
      .man_o   (rnd_man),
      .exp_o   (rnd_exp),
      .ovf_o   (rnd_ovf)
   );

   // Control FSM plus datapath registers; outputs load only when entering StOut.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         man_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         guard_q  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  man_q   <= sum_man_i;
                  exp_q   <= exp_in_i;
                  sign_q  <= sum_sign_i;
                  guard_q <= 1'b0;
                  state_q <= StNorm;
               end
            end
            StNorm: begin
               // Exponent only decreases while here, so max exponent means a captured Inf/NaN.
               if (exp_q == EXP_MAX) begin
                  result_q <= pack_fp(sign_q, EXP_MAX, man_q[ManW-1:0]);
                  ovf_q    <= 1'b0;
                  unf_q    <= 1'b0;
                  state_q  <= StOut;
               end else if (man_q == '0) begin
                  result_q <= '0;
                  ovf_q    <= 1'b0;
                  unf_q    <= 1'b0;
                  state_q  <= StOut;
               end else if (exp_q == '0) begin
                  result_q <= pack_fp(sign_q, ExpW'(man_q[ManW]), man_q[ManW-1:0]);
                  ovf_q    <= 1'b0;
                  unf_q    <= 1'b0;
                  state_q  <= StOut;
               end else if (man_q[ManW+1]) begin
                  guard_q <= man_q[0];
                  man_q   <= man_q >> 1;
                  exp_q   <= exp_q + ExpW'(1);
                  state_q <= StRound;
               end else if (man_q[ManW]) begin
                  result_q <= pack_fp(sign_q, exp_q, man_q[ManW-1:0]);
                  ovf_q    <= 1'b0;
                  unf_q    <= 1'b0;
                  state_q  <= StOut;
               end else if (exp_q == ExpW'(1)) begin
                  // Cannot shift further without going below the minimum normal exponent.
                  result_q <= pack_fp(sign_q, '0, man_q[ManW-1:0]);
                  ovf_q    <= 1'b0;
                  unf_q    <= 1'b1;
                  state_q  <= StOut;
               end else begin
                  man_q <= man_q << 1;
                  exp_q <= exp_q - ExpW'(1);
               end
            end
            StRound: begin
               if (rnd_ovf) begin
                  result_q <= pack_fp(sign_q, EXP_MAX, '0);
                  ovf_q    <= 1'b1;
               end else begin
                  result_q <= pack_fp(sign_q, rnd_exp, rnd_man[ManW-1:0]);
                  ovf_q    <= 1'b0;
               end
               unf_q   <= 1'b0;
               state_q <= StOut;
            end
            StOut: begin
               if (out_ready_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake outputs decode directly from the state register.
   always_comb begin
      in_ready_o  = (state_q == StIdle);
      out_valid_o = (state_q == StOut);
      result_o    = result_q;
      overflow_o  = ovf_q;
      underflow_o = unf_q;
   end

endmodule

// File: tb/tb_stage4_normalizer.sv
// Directed bench for stage4_normalizer: results, flags, latency, backpressure and async reset.
module tb_stage4_normalizer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] sum_man;
   logic        sum_sign;
   logic [7:0]  exp_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;

   int n_cmp = 0;
   int n_err = 0;

   stage4_normalizer u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .sum_man_i   (sum_man),
      .sum_sign_i  (sum_sign),
      .exp_in_i    (exp_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .overflow_o  (overflow),
      .underflow_o (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Issue one operation, measure latency from the acceptance edge and check the result.
   task automatic run_op(input string tag, input logic [24:0] man, input logic s,
                         input logic [7:0] e, input logic [31:0] exp_res, input int exp_lat,
                         input logic exp_ovf, input logic exp_unf);
      int cnt;
      @(negedge clk);
      sum_man  = man;
      sum_sign = s;
      exp_in   = e;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "/in_ready_low"}, 32'(in_ready), 32'd0);
      cnt = 0;
      do begin
         @(posedge clk);
         cnt++;
         #1;
      end while (!out_valid && cnt < 40);
      check({tag, "/latency"}, 32'(cnt + 1), 32'(exp_lat));
      check({tag, "/result"}, result, exp_res);
      check({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
      check({tag, "/underflow"}, 32'(underflow), 32'(exp_unf));
      @(posedge clk);
      #1;
      check({tag, "/out_valid_done"}, 32'(out_valid), 32'd0);
      check({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int cnt;
      logic [31:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      sum_man   = '0;
      sum_sign  = 1'b0;
      exp_in    = '0;
      out_ready = 1'b1;
      #1;
      check("reset/out_valid", 32'(out_valid), 32'd0);
      check("reset/in_ready", 32'(in_ready), 32'd1);
      check("reset/result", result, 32'h0000_0000);
      check("reset/flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("carry",      25'h100_0000, 1'b0, 8'd127, 32'h4000_0000, 3,  1'b0, 1'b0);
      run_op("normalized", 25'h0C0_0000, 1'b0, 8'd127, 32'h3FC0_0000, 2,  1'b0, 1'b0);
      run_op("zero",       25'h000_0000, 1'b1, 8'd127, 32'h0000_0000, 2,  1'b0, 1'b0);
      run_op("deep",       25'h000_0001, 1'b0, 8'd127, 32'h3400_0000, 25, 1'b0, 1'b0);
      run_op("denormal",   25'h000_0001, 1'b0, 8'd3,   32'h0000_0004, 4,  1'b0, 1'b1);
      run_op("tie_renorm", 25'h1FF_FFFF, 1'b0, 8'd127, 32'h4080_0000, 3,  1'b0, 1'b0);
      run_op("overflow",   25'h100_0000, 1'b0, 8'd254, 32'h7F80_0000, 3,  1'b1, 1'b0);
      run_op("negative",   25'h0C0_0000, 1'b1, 8'd130, 32'hC140_0000, 2,  1'b0, 1'b0);
      run_op("passthru",   25'h040_0001, 1'b0, 8'd255, 32'h7FC0_0001, 2,  1'b0, 1'b0);
      run_op("tie_even",   25'h100_0001, 1'b0, 8'd127, 32'h4000_0000, 3,  1'b0, 1'b0);
      run_op("round_up",   25'h100_0003, 1'b0, 8'd127, 32'h4000_0002, 3,  1'b0, 1'b0);
      run_op("denorm_in",  25'h080_0005, 1'b0, 8'd0,   32'h0080_0005, 2,  1'b0, 1'b0);

      // Backpressure: result and handshake must freeze while downstream stalls.
      out_ready = 1'b0;
      @(negedge clk);
      sum_man  = 25'h0C0_0000;
      sum_sign = 1'b0;
      exp_in   = 8'd127;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt = 0;
      do begin
         @(posedge clk);
         cnt++;
         #1;
      end while (!out_valid && cnt < 40);
      check("bp/result", result, 32'h3FC0_0000);
      held = result;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp/out_valid_held", 32'(out_valid), 32'd1);
         check("bp/result_held", result, 32'h3FC0_0000);
         check("bp/in_ready_held", 32'(in_ready), 32'd0);
      end
      check("bp/result_unchanged", result, held);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp/released", 32'(out_valid), 32'd0);
      check("bp/in_ready_back", 32'(in_ready), 32'd1);

      // Asynchronous reset in the middle of a long normalization.
      @(negedge clk);
      sum_man  = 25'h000_0001;
      sum_sign = 1'b0;
      exp_in   = 8'd127;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid/out_valid", 32'(out_valid), 32'd0);
      check("rst_mid/result", result, 32'h0000_0000);
      check("rst_mid/in_ready", 32'(in_ready), 32'd1);
      check("rst_mid/flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // No stale output from the discarded operation.
      repeat (30) @(posedge clk);
      #1;
      check("rst_mid/no_stale_valid", 32'(out_valid), 32'd0);

      run_op("after_rst",  25'h100_0000, 1'b0, 8'd127, 32'h4000_0000, 3,  1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stage4_normalizer.md
# stage4_normalizer

- Final stage of the 4-stage single-precision floating-point adder pipeline.
- Consumes the raw 25-bit magnitude sum, sign and common exponent from the stage-3 adder.
- Normalizes the sum with an iterative one-bit-per-cycle left shift, or a single right shift on carry-out, and rounds to nearest-even.
- Packs the IEEE-754 result and hands it downstream over a valid/ready handshake.

## Interface
- `MAN_W`, default 23: stored mantissa width.
- `EXP_W`, default 8: exponent width.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: stage-3 result present.
- `in_ready` output 1: block can accept; high only in IDLE.
- `sum_man` input 25: unsigned magnitude; bit 24 = carry, bit 23 = hidden-bit position.
- `sum_sign` input 1: result sign.
- `exp_in` input 8: biased common exponent from alignment.
- `out_valid` output 1: `result` valid.
- `out_ready` input 1: downstream accepts.
- `result` output 32: packed {sign, exp[7:0], frac[22:0]}.
- `overflow` output 1: result rounded to infinity.
- `underflow` output 1: result denormal or zero from a nonzero sum.

## Operation
- FSM states are IDLE, NORM, ROUND and OUT. The internal registers are `man` (25b), `exp` (8b), `sign`, `guard`, `ovf` and `unf`.
- **IDLE:** `in_ready`=1. When `in_valid`&&`in_ready`, capture the inputs, clear the flags and go to NORM.
- **NORM:** evaluated once per cycle, first match wins:
  - `exp_in`==255 (captured): pass-through. Pack {sign, 8'hFF, man[22:0]} and go to OUT.
  - `man`==0: pack 32'h0000_0000 (+0, sign dropped) and go to OUT.
  - `exp`==0: denormal input. The exp field is 1 if man[23] else 0, frac is man[22:0]. Go to OUT.
  - man[24]: set `guard`=man[0], man>>=1, exp+=1, go to ROUND.
  - man[23]: pack and go to OUT.
  - `exp`==1: denormal result. Pack with exp field 0, frac = man[22:0], set `unf`, go to OUT.
  - Otherwise: man<<=1, exp-=1, stay in NORM. At most 23 iterations.
- **ROUND:**
  - If `exp`==255, pack {sign, 8'hFF, 23'h0}, set `ovf` and go to OUT.
  - Otherwise, if `guard`&&man[0], do man+=1 (RNE; sticky is unavailable, so guard-only ties-to-even).
  - If the increment makes man[24] set: man>>=1, exp+=1.
  - Re-check `exp`==255, which means overflow to infinity.
  - Pack and go to OUT.
- **OUT:** `out_valid`=1. `result` and the flags are held stable until `out_ready`; then go to IDLE.
- **Arithmetic widths:** all exponent arithmetic is 8-bit unsigned. Decrement never goes below 1. Increment is checked against 255 before packing.
- **Reset:**
  - Any state returns to IDLE. `out_valid`=0, `result`=0, `overflow`=0, `underflow`=0, `in_ready`=1.
  - An in-flight operation is discarded with no output.

## Timing
- Acceptance edge is N.
- Latency to `out_valid` high, counted in cycles after N:
  - Already normalized, zero, pass-through or denormal input: 2.
  - Carry-out: 3.
  - k left shifts: 2+k. Worst case is 25.
- `in_ready` is combinational from state, so it falls in the cycle after acceptance. There is one operation in flight and no overlap; throughput is one result per latency+1 cycles with `out_ready` held high.
- `result`, `overflow` and `underflow` are registered and change only on the OUT entry edge.
- With `out_valid`&&!`out_ready`, all outputs are frozen.
- Output transfer happens on the edge where `out_valid`&&`out_ready`. `in_ready` is high the following cycle.
- Reset assertion clears the outputs immediately (asynchronous). Deassertion is synchronous to `clk` and is handled by the top-level reset synchronizer.

## Structure
- Shared package `fp_pkg` holds:
  - `MAN_W`, `EXP_W`, `EXP_MAX`=8'hFF, `BIAS`=127.
  - The `norm_state_t` enum (IDLE, NORM, ROUND, OUT).
  - A `pack_fp(sign, exp, frac)` function.
- One natural sub-module is `fp_round_rne`. It is combinational and takes man, exp and guard, and returns the rounded man/exp plus an overflow flag. It is reused by the multiplier team.
- The FSM and datapath registers stay in `stage4_normalizer`.

## Test plan
- **Carry-out:** `sum_man`=25'h100_0000, `exp_in`=127, sign 0 -> `result`=32'h4000_0000, latency 3, flags 0.
- **Normalized:** `sum_man`=25'h0C0_0000, `exp_in`=127 -> 32'h3FC0_0000 at latency 2.
- **Zero:** `sum_man`=0, `sign`=1 -> 32'h0000_0000 at latency 2.
- **Deep cancellation:** `sum_man`=25'h000_0001, `exp_in`=127 -> 32'h3400_0000 at latency 25.
- **Denormal:** `sum_man`=25'h000_0001, `exp_in`=3 -> 32'h0000_0004 at latency 4, `underflow`=1.
- **Round tie with renormalize:** `sum_man`=25'h1FF_FFFF, `exp_in`=127 -> 32'h4080_0000.
- **Overflow:** `sum_man`=25'h100_0000, `exp_in`=254 -> 32'h7F80_0000, `overflow`=1.
- **Backpressure and reset:**
  - Hold `out_ready`=0 for 5 cycles: `result` stays stable and `in_ready` stays 0.
  - Assert `rst` low mid-NORM: `out_valid`=0, `result`=0, `in_ready`=1 immediately.
  - The next accepted operation completes normally.
